// File: rtl/multiplicador_booth.sv
// Sequential N x N multiplier producing a 2N-bit product in {A, MQ}.
// Per operation it runs either unsigned shift-add or signed radix-2 Booth.
// The datapath adder is a ripple of 4-bit carry-lookahead slices (CLAA_1).

// 4-bit carry-lookahead adder slice.
module CLAA_1 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    // Lookahead carries computed directly from propagate/generate terms.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module multiplicador_booth #(
    parameter int N  = 8,
    parameter int CW = $clog2(N+1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           signed_mode,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   A,
    output logic [N-1:0]   MQ,
    output logic [2*N-1:0] product
);
    localparam int SLICES = N / 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic            capture;
    logic            step;
    logic [N-1:0]    m;
    logic            q_1;
    logic            mode;
    logic [CW-1:0]   count;
    logic [N-1:0]    bsel;
    logic            cin;
    logic [N-1:0]    sum;
    logic [SLICES:0] chain;
    logic            carry;
    logic            shift_in;

    assign chain[0] = cin;
    assign carry    = chain[SLICES];

    genvar i;
    generate
        for (i = 0; i < SLICES; i++) begin : g_slice
            CLAA_1 u_slice (
                .a   (A[4*i +: 4]),
                .b   (bsel[4*i +: 4]),
                .cin (chain[i]),
                .sum (sum[4*i +: 4]),
                .cout(chain[i+1])
            );
        end
    endgenerate

    // Adder operand selection. In signed mode the bit shifted into A is the
    // true sign of the (N+1)-bit sum, so an N-bit overflow of the partial sum
    // (e.g. 0 - (-2^(N-1))) still yields an exact final product.
    always_comb begin
        bsel = '0;
        cin  = 1'b0;
        if (!mode) begin
            if (MQ[0]) bsel = m;
        end else begin
            case ({MQ[0], q_1})
                2'b01:   bsel = m;
                2'b10: begin
                    bsel = ~m;
                    cin  = 1'b1;
                end
                default: bsel = '0;
            endcase
        end
        shift_in = mode ? (A[N-1] ^ bsel[N-1] ^ carry) : carry;
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic plus capture/iterate strobes for the datapath.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    capture    = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == CW'(1)) next_state = DONE;
            end
            DONE: begin
                if (load) begin
                    capture    = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand capture on load, one add-and-shift per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            A     <= '0;
            MQ    <= '0;
            m     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            mode  <= 1'b0;
        end else if (capture) begin
            A     <= '0;
            MQ    <= y;
            m     <= x;
            q_1   <= 1'b0;
            count <= CW'(N);
            mode  <= signed_mode;
        end else if (step) begin
            A     <= {shift_in, sum[N-1:1]};
            MQ    <= {sum[0], MQ[N-1:1]};
            q_1   <= MQ[0];
            count <= count - CW'(1);
        end
    end

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign product = {A, MQ};
endmodule

// File: tb/tb_multiplicador_booth.sv
// Self-checking bench for multiplicador_booth: directed vectors plus
// randomized operations compared against a plain-arithmetic product model.
module tb_multiplicador_booth;
    parameter int N = 8;
    localparam int CW = $clog2(N+1);

    logic           clk = 1'b0;
    logic           reset;
    logic           load;
    logic           signed_mode;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic           busy;
    logic           done;
    logic [N-1:0]   A;
    logic [N-1:0]   MQ;
    logic [2*N-1:0] product;

    int checks   = 0;
    int failures = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    multiplicador_booth #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .signed_mode(signed_mode),
        .x          (x),
        .y          (y),
        .busy       (busy),
        .done       (done),
        .A          (A),
        .MQ         (MQ),
        .product    (product)
    );

    // Reference product: plain integer multiplication truncated to 2N bits.
    function automatic logic [2*N-1:0] ref_product(input logic s, input logic [N-1:0] a,
                                                   input logic [N-1:0] b);
        longint pa;
        longint pb;
        longint pr;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'(a);
            pb = longint'(b);
        end
        pr = pa * pb;
        return pr[2*N-1:0];
    endfunction

    // Drives one operation and waits (bounded) for done; operands are
    // scrambled right after the load cycle.
    task automatic run_op(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                          output int lat, output int busy_cnt, output logic ok);
        @(negedge clk);
        signed_mode = s;
        x = a;
        y = b;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        x = N'($urandom);
        y = N'($urandom);
        signed_mode = 1'($urandom);
        lat = 1;
        busy_cnt = 0;
        while (!done && lat <= N + 6) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load = 1'b1;
        signed_mode = 1'b1;
        x = '1;
        y = '1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got %b want 0", done); end
        checks++;
        if (product !== '0) begin failures++; $display("[TB] FAIL reset_product got %h want 0", product); end
        load = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || product !== '0) begin
            failures++;
            $display("[TB] FAIL idle_hold busy=%b product=%h want 0/0", busy, product);
        end
    endtask

    task automatic test_unsigned_max();
        int lat;
        int bc;
        logic ok;
        logic [2*N-1:0] exp_p;
        logic [N-1:0] ones;
        ones = '1;
        exp_p = ref_product(1'b0, ones, ones);
        run_op(1'b0, ones, ones, lat, bc, ok);
        checks++;
        if (!ok || lat != N + 1) begin
            failures++;
            $display("[TB] FAIL umax_latency got %0d (done=%b) want %0d", lat, ok, N + 1);
        end
        checks++;
        if (bc != N) begin failures++; $display("[TB] FAIL umax_busy_cycles got %0d want %0d", bc, N); end
        checks++;
        if (product !== exp_p) begin failures++; $display("[TB] FAIL umax_product got %h want %h", product, exp_p); end
        checks++;
        if (A !== exp_p[2*N-1:N] || MQ !== exp_p[N-1:0]) begin
            failures++;
            $display("[TB] FAIL umax_halves got %h/%h want %h/%h", A, MQ, exp_p[2*N-1:N], exp_p[N-1:0]);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL done_single_pulse got %b want 0", done); end
        repeat (3) @(negedge clk);
        checks++;
        if (product !== exp_p || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL result_hold got %h busy=%b want %h busy=0", product, busy, exp_p);
        end
    endtask

    task automatic test_directed(input string name, input logic s, input logic [N-1:0] a,
                                 input logic [N-1:0] b);
        int lat;
        int bc;
        logic ok;
        logic [2*N-1:0] exp_p;
        exp_p = ref_product(s, a, b);
        run_op(s, a, b, lat, bc, ok);
        checks++;
        if (!ok || product !== exp_p || lat != N + 1) begin
            failures++;
            $display("[TB] FAIL %s got %h (done=%b lat=%0d) want %h lat=%0d", name, product, ok, lat, exp_p, N + 1);
        end
    endtask

    task automatic test_signed_vectors();
        logic [N-1:0] mn;
        logic [N-1:0] mx;
        mn = {1'b1, {(N-1){1'b0}}};
        mx = {1'b0, {(N-1){1'b1}}};
        test_directed("signed_m3_x_5", 1'b1, N'(-3), N'(5));
        test_directed("signed_min_x_min", 1'b1, mn, mn);
        test_directed("signed_max_x_min", 1'b1, mx, mn);
        test_directed("signed_min_x_m1", 1'b1, mn, '1);
    endtask

    task automatic test_mode_isolation();
        test_directed("unsigned_zero", 1'b0, '0, N'(8'hA5));
        test_directed("signed_1_x_m1", 1'b1, N'(1), '1);
        test_directed("unsigned_1_x_ones", 1'b0, N'(1), '1);
    endtask

    task automatic test_load_ignored();
        logic s1;
        logic [N-1:0] a1;
        logic [N-1:0] b1;
        logic [2*N-1:0] exp_p;
        logic [2*N-1:0] dprod;
        int lat;
        int pulses;
        int dlat;
        s1 = 1'($urandom);
        a1 = N'($urandom);
        b1 = N'($urandom);
        exp_p = ref_product(s1, a1, b1);
        pulses = 0;
        dlat = 0;
        dprod = '0;
        @(negedge clk);
        signed_mode = s1;
        x = a1;
        y = b1;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        lat = 1;
        for (int k = 0; k < 2*N + 4; k++) begin
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    dlat = lat;
                    dprod = product;
                end
            end
            if (lat == 3) begin
                load = 1'b1;
                signed_mode = ~s1;
                x = ~a1;
                y = ~b1 ^ N'(1);
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (pulses != 1 || dlat != N + 1) begin
            failures++;
            $display("[TB] FAIL load_in_run_pulses got %0d at %0d want 1 at %0d", pulses, dlat, N + 1);
        end
        checks++;
        if (dprod !== exp_p) begin failures++; $display("[TB] FAIL load_in_run_product got %h want %h", dprod, exp_p); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int bc;
        int pulses;
        logic ok;
        @(negedge clk);
        signed_mode = 1'b0;
        x = '1;
        y = '1;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || A !== '0 || MQ !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mid_run got busy=%b done=%b A=%h MQ=%h want 0/0/0/0", busy, done, A, MQ);
        end
        pulses = 0;
        repeat (N + 4) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("[TB] FAIL reset_no_done got %0d active cycles want 0", pulses); end
        test_directed("after_reset_op", 1'b1, N'(-3), N'(5));
        run_op(1'b0, N'(3), N'(7), lat, bc, ok);
        checks++;
        if (!ok || bc != N || product !== ref_product(1'b0, N'(3), N'(7))) begin
            failures++;
            $display("[TB] FAIL after_reset_second got %h busy=%0d want %h busy=%0d", product, bc,
                     ref_product(1'b0, N'(3), N'(7)), N);
        end
    endtask

    task automatic test_back_to_back();
        logic         s_set [2];
        logic [N-1:0] a_set [2];
        logic [N-1:0] b_set [2];
        int idx;
        int since;
        int cyc;
        s_set[0] = 1'b0; a_set[0] = '1;                      b_set[0] = '1;
        s_set[1] = 1'b1; a_set[1] = {1'b1, {(N-1){1'b0}}};   b_set[1] = N'(-3);
        idx = 0;
        since = 0;
        cyc = 0;
        @(negedge clk);
        signed_mode = s_set[0];
        x = a_set[0];
        y = b_set[0];
        load = 1'b1;
        while (idx < 6 && cyc < 6*(N+1) + 20) begin
            @(negedge clk);
            cyc++;
            since++;
            if (done) begin
                checks++;
                if (product !== ref_product(s_set[idx%2], a_set[idx%2], b_set[idx%2]) || since != N + 1) begin
                    failures++;
                    $display("[TB] FAIL b2b_op%0d got %h after %0d want %h after %0d", idx, product, since,
                             ref_product(s_set[idx%2], a_set[idx%2], b_set[idx%2]), N + 1);
                end
                idx++;
                since = 0;
                signed_mode = s_set[idx%2];
                x = a_set[idx%2];
                y = b_set[idx%2];
                if (idx == 6) load = 1'b0;
            end
        end
        load = 1'b0;
        checks++;
        if (idx != 6) begin failures++; $display("[TB] FAIL b2b_count got %0d want 6", idx); end
    endtask

    task automatic test_random();
        int lat;
        int bc;
        logic ok;
        logic s;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2*N-1:0] exp_p;
        for (int k = 0; k < 1000; k++) begin
            s = 1'($urandom);
            a = N'($urandom);
            b = N'($urandom);
            exp_p = ref_product(s, a, b);
            run_op(s, a, b, lat, bc, ok);
            checks++;
            if (!ok || lat != N + 1 || product !== exp_p) begin
                failures++;
                $display("[TB] FAIL random%0d s=%b x=%h y=%h got %h lat=%0d want %h lat=%0d", k, s, a, b,
                         product, lat, exp_p, N + 1);
            end
        end
    endtask

    // Test sequence.
    initial begin
        reset = 1'b1;
        load = 1'b0;
        signed_mode = 1'b0;
        x = '0;
        y = '0;
        test_reset();
        test_unsigned_max();
        test_signed_vectors();
        test_mode_isolation();
        test_load_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
